// File: rtl/shift_engine_pkg.sv
// -----------------------------------------------------------------------------
// shift_engine_pkg
//   Shared types for the shift engine.
//   - state_t : transfer FSM states (ST_IDLE, ST_SHIFT)
//   - order_t : bit order captured at load (ORD_MSB, ORD_LSB)
// -----------------------------------------------------------------------------
package shift_engine_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic {
    ORD_MSB = 1'b0,
    ORD_LSB = 1'b1
  } order_t;

  // Map the raw lsbFirst pin onto the order type.
  function automatic order_t order_from_pin(input logic lsb_first);
    return lsb_first ? ORD_LSB : ORD_MSB;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
//   Counts bits shifted in the current transfer.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : synchronous clear to 0 (wins over inc)
//     inc         : add one
//     count       : current bit count (CNT_W bits)
//     last        : count == WIDTH-1, i.e. the next shift is the final one
// -----------------------------------------------------------------------------
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/shift_engine.sv
// -----------------------------------------------------------------------------
// shift_engine
//   Parallel-load / serial-shift register with transfer control. A load starts a
//   WIDTH-bit transfer; each peripheral clock edge strobe shifts one bit out and
//   captures one bit in. Bit order (MSB or LSB first) is latched at load.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     peripheralClkEdge  : 1-cycle shift strobe
//     parallelLoad       : load parallelDataIn and (re)start a transfer
//     lsbFirst           : bit order for the next transfer (sampled at load)
//     parallelDataIn     : word to transmit
//     serialDataIn       : received bit, captured on each strobe
//     parallelDataOut    : shift register contents
//     serialDataOut      : current outgoing bit
//     busy               : transfer in progress
//     done               : 1-cycle pulse after the final bit
//     bitCount           : bits shifted so far (holds WIDTH after completion)
// -----------------------------------------------------------------------------
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic             lsbFirst,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bitCount
);

  state_t           state, state_next;
  order_t           order_q;
  logic [WIDTH-1:0] shift_q;
  logic             done_q;

  logic             load_en;
  logic             shift_en;
  logic             finish;
  logic             last_bit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (parallelLoad) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A load restarts the transfer and keeps us in SHIFT.
        if (!parallelLoad && peripheralClkEdge && last_bit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    load_en  = parallelLoad;
    shift_en = 1'b0;
    finish   = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        // Load wins over a coincident strobe; the strobe is simply dropped.
        shift_en = peripheralClkEdge && !parallelLoad;
        finish   = shift_en && last_bit;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register and latched bit order
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      order_q <= ORD_MSB;
    end else if (load_en) begin
      shift_q <= parallelDataIn;
      order_q <= order_from_pin(lsbFirst);
    end else if (shift_en) begin
      if (order_q == ORD_LSB) begin
        shift_q <= {serialDataIn, shift_q[WIDTH-1:1]};
      end else begin
        shift_q <= {shift_q[WIDTH-2:0], serialDataIn};
      end
    end
  end

  // Completion pulse: registered so it is high for exactly the cycle after the
  // final strobe. Reset drops it, so an abandoned transfer never signals done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit counter
  // ---------------------------------------------------------------------------
  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load_en),
    .inc   (shift_en),
    .count (bitCount),
    .last  (last_bit)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign parallelDataOut = shift_q;
  assign serialDataOut   = (order_q == ORD_LSB) ? shift_q[0] : shift_q[WIDTH-1];
  assign done            = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_engine
//   Two instances (WIDTH=8 and WIDTH=16) driven from one clock. A reference
//   model tracks each instance's word as an integer and applies the shift rules
//   with plain arithmetic; directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_shift_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=8 instance signals
  logic        ld8, lsb8, stb8, sin8;
  logic [7:0]  din8;
  logic [7:0]  pout8;
  logic        sout8, busy8, done8;
  logic [3:0]  cnt8;

  // WIDTH=16 instance signals
  logic        ld16, lsb16, stb16, sin16;
  logic [15:0] din16;
  logic [15:0] pout16;
  logic        sout16, busy16, done16;
  logic [4:0]  cnt16;

  shift_engine #(.WIDTH(8)) dut8 (
    .clk               (clk),
    .rst_n             (rst_n),
    .peripheralClkEdge (stb8),
    .parallelLoad      (ld8),
    .lsbFirst          (lsb8),
    .parallelDataIn    (din8),
    .serialDataIn      (sin8),
    .parallelDataOut   (pout8),
    .serialDataOut     (sout8),
    .busy              (busy8),
    .done              (done8),
    .bitCount          (cnt8)
  );

  shift_engine #(.WIDTH(16)) dut16 (
    .clk               (clk),
    .rst_n             (rst_n),
    .peripheralClkEdge (stb16),
    .parallelLoad      (ld16),
    .lsbFirst          (lsb16),
    .parallelDataIn    (din16),
    .serialDataIn      (sin16),
    .parallelDataOut   (pout16),
    .serialDataOut     (sout16),
    .busy              (busy16),
    .done              (done16),
    .bitCount          (cnt16)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = WIDTH 8, index 1 = WIDTH 16.
  int m_reg  [2];
  int m_lsb  [2];
  int m_cnt  [2];
  int m_busy [2];
  int m_done [2];

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_reg[i]  = 0;
      m_lsb[i]  = 0;
      m_cnt[i]  = 0;
      m_busy[i] = 0;
      m_done[i] = 0;
    end
  endtask

  task automatic idle_inputs();
    ld8 = 0; lsb8 = 0; stb8 = 0; sin8 = 0; din8 = '0;
    ld16 = 0; lsb16 = 0; stb16 = 0; sin16 = 0; din16 = '0;
  endtask

  // One clock cycle: drive instance k, advance the model, compare both instances.
  task automatic cycle(input int k, input bit load, input bit order,
                       input int data, input bit strobe, input bit sbit);
    idle_inputs();
    if (k == 0) begin
      ld8 = load; lsb8 = order; din8 = 8'(data); stb8 = strobe; sin8 = sbit;
    end else begin
      ld16 = load; lsb16 = order; din16 = 16'(data); stb16 = strobe; sin16 = sbit;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int  w;
      int  mask;
      bit  l, s, b;
      w    = width_of(i);
      mask = (1 << w) - 1;
      l    = (i == k) && load;
      s    = (i == k) && strobe;
      b    = (i == k) && sbit;
      m_done[i] = 0;
      if (l) begin
        m_reg[i]  = data & mask;
        m_lsb[i]  = int'(order);
        m_cnt[i]  = 0;
        m_busy[i] = 1;
      end else if (m_busy[i] != 0 && s) begin
        if (m_lsb[i] != 0) m_reg[i] = (m_reg[i] >> 1) | (int'(b) << (w - 1));
        else               m_reg[i] = ((m_reg[i] << 1) | int'(b)) & mask;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == w) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [15:0] a_reg;
      logic [4:0]  a_cnt;
      logic        a_sout, a_busy, a_done, e_sout;
      a_reg  = (i == 0) ? {8'h00, pout8} : pout16;
      a_cnt  = (i == 0) ? {1'b0, cnt8} : cnt16;
      a_sout = (i == 0) ? sout8 : sout16;
      a_busy = (i == 0) ? busy8 : busy16;
      a_done = (i == 0) ? done8 : done16;
      e_sout = (m_lsb[i] != 0) ? m_reg[i][0] : m_reg[i][width_of(i) - 1];
      checks++;
      if (a_reg !== 16'(m_reg[i])) begin
        errors++;
        $display("FAIL w%0d parallelDataOut @%0t: got %h expected %h", width_of(i), $time, a_reg, 16'(m_reg[i]));
      end
      checks++;
      if (a_cnt !== 5'(m_cnt[i])) begin
        errors++;
        $display("FAIL w%0d bitCount @%0t: got %0d expected %0d", width_of(i), $time, a_cnt, m_cnt[i]);
      end
      checks++;
      if (a_sout !== e_sout) begin
        errors++;
        $display("FAIL w%0d serialDataOut @%0t: got %b expected %b", width_of(i), $time, a_sout, e_sout);
      end
      checks++;
      if (a_busy !== 1'(m_busy[i])) begin
        errors++;
        $display("FAIL w%0d busy @%0t: got %b expected %0d", width_of(i), $time, a_busy, m_busy[i]);
      end
      checks++;
      if (a_done !== 1'(m_done[i])) begin
        errors++;
        $display("FAIL w%0d done @%0t: got %b expected %0d", width_of(i), $time, a_done, m_done[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pout8, sout8, busy8, done8, cnt8} !== 16'h0) begin
      errors++;
      $display("FAIL reset w8: got reg=%h sout=%b busy=%b done=%b cnt=%0d expected all 0",
               pout8, sout8, busy8, done8, cnt8);
    end
    checks++;
    if ({pout16, sout16, busy16, done16, cnt16} !== 24'h0) begin
      errors++;
      $display("FAIL reset w16: got reg=%h sout=%b busy=%b done=%b cnt=%0d expected all 0",
               pout16, sout16, busy16, done16, cnt16);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_strobes(input logic [7:0] exp_reg, input logic [3:0] exp_cnt);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 1);
      checks++;
      if (pout8 !== exp_reg || cnt8 !== exp_cnt || done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL idle strobe: got reg=%h cnt=%0d done=%b busy=%b expected reg=%h cnt=%0d done=0 busy=0",
                 pout8, cnt8, done8, busy8, exp_reg, exp_cnt);
      end
    end
  endtask

  // Shared body for the two fixed-pattern transfers.
  task automatic run_fixed(input string name, input bit order, input logic [7:0] word,
                           input bit sbit, input logic [7:0] seq, input logic [7:0] final_word);
    cycle(0, 1, order, int'(word), 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout8 !== seq[7 - i]) begin
        errors++;
        $display("FAIL %s serial bit %0d: got %b expected %b", name, i, sout8, seq[7 - i]);
      end
      cycle(0, 0, 0, 0, 1, sbit);
      checks++;
      if (done8 !== (i == 7)) begin
        errors++;
        $display("FAIL %s done after strobe %0d: got %b expected %b", name, i + 1, done8, (i == 7));
      end
    end
    checks++;
    if (pout8 !== final_word || cnt8 !== 4'd8 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s final: got reg=%h cnt=%0d busy=%b expected reg=%h cnt=8 busy=0",
               name, pout8, cnt8, busy8, final_word);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (done8 !== 1'b0 || cnt8 !== 4'd8) begin
      errors++;
      $display("FAIL %s done width: got done=%b cnt=%0d expected done=0 cnt=8", name, done8, cnt8);
    end
  endtask

  task automatic test_msb_first();
    run_fixed("msb_first", 1'b0, 8'h0F, 1'b1, 8'b0000_1111, 8'hFF);
  endtask

  task automatic test_lsb_first();
    run_fixed("lsb_first", 1'b1, 8'hA5, 1'b0, 8'b1010_0101, 8'h00);
  endtask

  task automatic test_restart();
    cycle(0, 1, 0, 'h3C, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
    cycle(0, 1, 0, 'hC3, 1, 1);
    checks++;
    if (pout8 !== 8'hC3 || cnt8 !== 4'd0 || busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL restart: got reg=%h cnt=%0d busy=%b done=%b expected reg=c3 cnt=0 busy=1 done=0",
               pout8, cnt8, busy8, done8);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0, 1, 1'($urandom_range(0, 1)));
      checks++;
      if (done8 !== (i == 7) || cnt8 !== 4'(i + 1)) begin
        errors++;
        $display("FAIL restart strobe %0d: got done=%b cnt=%0d expected done=%b cnt=%0d",
                 i + 1, done8, cnt8, (i == 7), i + 1);
      end
    end
  endtask

  task automatic test_width16_reset();
    cycle(1, 1, 0, 'h8001, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pout16, sout16, busy16, done16, cnt16} !== 24'h0) begin
      errors++;
      $display("FAIL w16 mid-transfer reset: got reg=%h sout=%b busy=%b done=%b cnt=%0d expected all 0",
               pout16, sout16, busy16, done16, cnt16);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL w16 reset no done: got done=%b busy=%b expected 0 0", done16, busy16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
      checks++;
      if (done16 !== (i == 15)) begin
        errors++;
        $display("FAIL w16 done after strobe %0d: got %b expected %b", i + 1, done16, (i == 15));
      end
    end
    checks++;
    if (cnt16 !== 5'd16 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL w16 final: got cnt=%0d busy=%b expected cnt=16 busy=0", cnt16, busy16);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int  k;
      bit  load;
      k    = int'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0) || (m_busy[k] == 0 && $urandom_range(0, 2) == 0);
      cycle(k, load, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive loads with continuous strobes on both widths.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 3; t++) begin
        cycle(k, 1, 1'(t), int'($urandom_range(0, 65535)), 1, 1);
        for (int i = 0; i < width_of(k); i++) cycle(k, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_idle_strobes(8'h00, 4'd0);
    test_msb_first();
    test_lsb_first();
    test_idle_strobes(8'h00, 4'd8);
    test_restart();
    test_width16_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
